path_streamer: RTL
==================

PATH_STREAMER -- requirements
Module: path_streamer

Interface
REQ-001 SHALL have parameter NODE_COUNT, default 19, number of graph nodes.
REQ-002 SHALL have parameter MAX_SLOTS, default 10, number of 5-bit slots in the packed path word.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port done, input, 1 bit, path-ready level from the shortest-path engine (stays high once set).
REQ-006 SHALL have port final_path, input, 50 bits, packed reversed path; slot k = bits [5k+4:5k].
REQ-007 SHALL have port node_out, output, 5 bits, current node index in forward (source-first) order.
REQ-008 SHALL have port node_valid, output, 1 bit; node_out is valid.
REQ-009 SHALL have port node_ready, input, 1 bit, downstream accept.
REQ-010 SHALL have port node_last, output, 1 bit; the current beat is the destination node.
REQ-011 SHALL have port hop_count, output, 4 bits, number of edges in the path (path length - 1).
REQ-012 SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-013 SHALL have port path_end, output, 1 bit, one-cycle pulse when a path completes.
REQ-014 SHALL have port err, output, 1 bit, sticky path-format error.

Function
REQ-015 Slot layout SHALL be: slot0 = destination, then predecessors, then source, then terminator 27 (5'b11011).
REQ-016 Path length L SHALL be the index of the first slot equal to 27; if no slot holds 27, L = MAX_SLOTS.
REQ-017 The state machine SHALL have states IDLE, SCAN, STREAM and FINISH.
REQ-018 In IDLE, a rising edge of done (done & ~done_q) SHALL latch final_path into an internal buffer, set idx=0 and move to SCAN.
REQ-019 SCAN SHALL examine one slot per cycle, at slot idx.
REQ-020 In SCAN, if slot[idx]==27, the block SHALL set L=idx and hop_count=idx-1, set ptr=idx-1, and move to STREAM (or to FINISH when idx==0).
REQ-021 In SCAN, if idx==MAX_SLOTS-1 and the slot is not 27, the block SHALL set L=MAX_SLOTS and ptr=MAX_SLOTS-1 and move to STREAM.
REQ-022 In STREAM, the block SHALL drive node_valid=1, node_out=slot[ptr] and node_last=(ptr==0).
REQ-023 node_out and node_last SHALL be held stable while node_valid & ~node_ready.
REQ-024 On node_valid & node_ready, the block SHALL decrement ptr, or move to FINISH when ptr==0.
REQ-025 FINISH SHALL assert path_end for exactly one cycle and then return to IDLE.
REQ-026 An empty path (L==0) SHALL give hop_count=0 and no beats.
REQ-027 done edges arriving while busy SHALL be ignored, and done_q SHALL keep tracking done.
REQ-028 A still-high done SHALL NOT retrigger a capture; only a new 0->1 transition does.
REQ-029 hop_count SHALL be held from the end of SCAN until the next capture.
REQ-030 First-beat latency SHALL be 1 cycle of edge detection plus (term_idx+1) SCAN cycles.

Reset
REQ-031 When reset is high at a clock edge, the block SHALL enter IDLE, with the FSM state taking priority over all other updates.
REQ-032 Reset SHALL force node_out=0, node_valid=0, node_last=0, hop_count=0, busy=0, path_end=0, err=0 and done_q=0.
REQ-033 Reset asserted mid-stream SHALL abort the stream with no path_end; if done is still high after reset, the block SHALL NOT capture again until done falls and rises.

Configuration
REQ-034 Macro PATH_CHECK_EN SHALL enable path validation.
REQ-035 With PATH_CHECK_EN defined, SCAN SHALL check every slot before the terminator.
REQ-036 With PATH_CHECK_EN defined, a slot value >= NODE_COUNT and != 27, or a missing terminator, SHALL set err, suppress streaming and go directly to FINISH.
REQ-037 With PATH_CHECK_EN defined, err SHALL clear on the next capture.
REQ-038 Without PATH_CHECK_EN, err SHALL be tied 0 and any slot values SHALL be streamed unchecked.

Structure
REQ-039 A shared package SHALL hold NODE_W=5, NODE_COUNT=19, MAX_SLOTS=10, PATH_TERM=5'd27 and the state enum.
REQ-040 The block SHALL have no sub-module; edge detection and slot mux are inline.

Verification
REQ-041 Slots {5,1,0,27,27,...} with a done rise SHALL give beats 0,1,5 with node_last on 5, hop_count=2, and first node_valid 5 cycles after the done rise.
REQ-042 The same path with node_ready low for 3 cycles on the second beat SHALL hold node_out=1 stable, with no loss or duplication.
REQ-043 Slot0=27 SHALL give no beats, a path_end pulse and hop_count=0.
REQ-044 No 27 in any slot SHALL stream 10 beats from slot9 down to slot0 without PATH_CHECK_EN, and SHALL set err with no beats with PATH_CHECK_EN.
REQ-045 Slots {5,20,0,27,...} with PATH_CHECK_EN SHALL give err=1, no beats and a path_end pulse.
REQ-046 Reset after the first beat with done held high SHALL produce no further beats until done toggles 1->0->1, after which the full path restreams.

Source files
------------

// File: rtl/path_streamer_pkg.sv
// path_streamer_pkg: shared widths, limits and FSM states for the path streamer
package path_streamer_pkg;
  localparam int NODE_W = 5;
  localparam int NODE_COUNT = 19;
  localparam int MAX_SLOTS = 10;
  localparam logic [NODE_W-1:0] PATH_TERM = 5'd27;
  typedef enum logic [1:0] {IDLE, SCAN, STREAM, FINISH} state_e;
endpackage

// File: rtl/path_streamer.sv
// path_streamer: replays a reversed packed shortest path as a source-first ready/valid node stream (PATH_CHECK_EN adds slot validation)
module path_streamer
  import path_streamer_pkg::*;
#(
  parameter int NODE_COUNT = path_streamer_pkg::NODE_COUNT,
  parameter int MAX_SLOTS = path_streamer_pkg::MAX_SLOTS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        done,
  input  logic [NODE_W*MAX_SLOTS-1:0] final_path,
  output logic [NODE_W-1:0]           node_out,
  output logic                        node_valid,
  input  logic                        node_ready,
  output logic                        node_last,
  output logic [3:0]                  hop_count,
  output logic                        busy,
  output logic                        path_end,
  output logic                        err
);
  localparam int IW = $clog2(MAX_SLOTS);
  localparam logic [IW-1:0] LAST = IW'(MAX_SLOTS - 1);
`ifdef PATH_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  state_e state_q, state_d;
  logic [MAX_SLOTS-1:0][NODE_W-1:0] buf_q, buf_d;
  logic [IW-1:0] idx_q, idx_d, ptr_q, ptr_d;
  logic [3:0] hop_q, hop_d;
  logic err_q, err_d, done_q, armed_q;
  logic [NODE_W-1:0] scan_slot;
  logic capture, bad_node;
  // armed_q blocks a capture until done has been seen low, so a level held across reset cannot retrigger
  assign capture = done & ~done_q & armed_q;
  assign scan_slot = buf_q[idx_q];
  assign bad_node = CHK && scan_slot != PATH_TERM && scan_slot >= NODE_W'(NODE_COUNT);
  assign node_valid = state_q == STREAM;
  assign node_out = node_valid ? buf_q[ptr_q] : '0;
  assign node_last = node_valid && ptr_q == '0;
  assign hop_count = hop_q;
  assign busy = state_q != IDLE;
  assign path_end = state_q == FINISH;
  assign err = err_q;
  // next state: capture, one-slot-per-cycle terminator scan, backward stream from ptr to slot0
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    hop_d = hop_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (capture) begin
        state_d = SCAN;
        buf_d = final_path;
        idx_d = '0;
        err_d = 1'b0;
      end
      SCAN: if (scan_slot == PATH_TERM) begin
        hop_d = idx_q == '0 ? 4'd0 : 4'(idx_q - 1'b1);
        ptr_d = idx_q - 1'b1;
        state_d = idx_q == '0 ? FINISH : STREAM;
      end else if (bad_node || (CHK && idx_q == LAST)) begin
        err_d = 1'b1;
        state_d = FINISH;
      end else if (idx_q == LAST) begin
        hop_d = 4'(MAX_SLOTS - 1);
        ptr_d = LAST;
        state_d = STREAM;
      end else begin
        idx_d = idx_q + 1'b1;
      end
      STREAM: if (node_ready) begin
        state_d = ptr_q == '0 ? FINISH : STREAM;
        ptr_d = ptr_q == '0 ? ptr_q : ptr_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset returns to IDLE and clears all outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      hop_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      armed_q <= ~done;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      hop_q <= hop_d;
      err_q <= err_d;
      done_q <= done;
      armed_q <= armed_q | ~done;
    end
  end
endmodule
